// File: rtl/cu_pkg.sv
// rtl/cu_pkg.sv - shared opcodes, state encoding and writeback-source codes for the control unit
// HALT state exists only when CU_ILLEGAL_TRAP_EN is defined.
package cu_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;
    localparam logic [1:0] WB_IMM = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_IF,
        S_ID,
        S_EX,
        S_MEM,
        S_WB
`ifdef CU_ILLEGAL_TRAP_EN
        , S_HALT
`endif
    } state_e;

endpackage

// File: rtl/cu_decoder.sv
// rtl/cu_decoder.sv - combinational opcode decode into datapath steering and FSM routing flags
module cu_decoder
    import cu_pkg::*;
(
    input  logic [6:0] opcode_i,
    output logic       jump_o,
    output logic       imm_o,
    output logic       expc_o,
    output logic       l_or_s_o,
    output logic [1:0] wb_ctrl_o,
    output logic       is_mem_o,
    output logic       is_store_o,
    output logic       has_wb_o,
    output logic       legal_o
);

    always_comb begin
        jump_o     = 1'b0;
        imm_o      = 1'b0;
        expc_o     = 1'b0;
        l_or_s_o   = 1'b0;
        wb_ctrl_o  = WB_ALU;
        is_mem_o   = 1'b0;
        is_store_o = 1'b0;
        has_wb_o   = 1'b0;
        legal_o    = 1'b1;
        case (opcode_i)
            OPC_LOAD: begin
                imm_o     = 1'b1;
                wb_ctrl_o = WB_MEM;
                is_mem_o  = 1'b1;
                has_wb_o  = 1'b1;
            end
            OPC_STORE: begin
                imm_o      = 1'b1;
                l_or_s_o   = 1'b1;
                is_mem_o   = 1'b1;
                is_store_o = 1'b1;
            end
            OPC_OP: begin
                has_wb_o = 1'b1;
            end
            OPC_OPIMM: begin
                imm_o    = 1'b1;
                has_wb_o = 1'b1;
            end
            OPC_LUI: begin
                imm_o     = 1'b1;
                wb_ctrl_o = WB_IMM;
                has_wb_o  = 1'b1;
            end
            OPC_AUIPC: begin
                imm_o    = 1'b1;
                expc_o   = 1'b1;
                has_wb_o = 1'b1;
            end
            OPC_JAL: begin
                jump_o    = 1'b1;
                imm_o     = 1'b1;
                expc_o    = 1'b1;
                wb_ctrl_o = WB_PC4;
                has_wb_o  = 1'b1;
            end
            OPC_JALR: begin
                jump_o    = 1'b1;
                imm_o     = 1'b1;
                wb_ctrl_o = WB_PC4;
                has_wb_o  = 1'b1;
            end
            OPC_BRANCH: begin
                jump_o = 1'b1;
                expc_o = 1'b1;
            end
            default: begin
                legal_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - multi-cycle IF/ID/EX/MEM/WB sequencer with registered opcode decode
// Optional illegal-opcode HALT trap and illegal port under CU_ILLEGAL_TRAP_EN.
module control_unit
    import cu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] ALUSEL,
    output logic       PC_en,
    output logic       ID_en,
    output logic       EX_en,
    output logic       MEM_en,
    output logic       WB_en,
    output logic       Jump_en,
    output logic       imm_en,
    output logic       EXPC_en,
    output logic       L_or_S,
    output logic [1:0] WB_Ctrl
`ifdef CU_ILLEGAL_TRAP_EN
    ,
    output logic       illegal
`endif
);

    state_e     state_q, state_d;
    logic [6:0] opcode_q, opcode_d;

    logic       dec_jump, dec_imm, dec_expc, dec_l_or_s;
    logic [1:0] dec_wb_ctrl;
    logic       dec_is_mem, dec_is_store, dec_has_wb, dec_legal;

    cu_decoder u_decoder (
        .opcode_i   (opcode_q),
        .jump_o     (dec_jump),
        .imm_o      (dec_imm),
        .expc_o     (dec_expc),
        .l_or_s_o   (dec_l_or_s),
        .wb_ctrl_o  (dec_wb_ctrl),
        .is_mem_o   (dec_is_mem),
        .is_store_o (dec_is_store),
        .has_wb_o   (dec_has_wb),
        .legal_o    (dec_legal)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            opcode_q <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
        end
    end

    // Opcode is latched only on the ID exit edge so decode holds through EX/MEM/WB.
    always_comb begin
        opcode_d = (state_q == S_ID) ? ALUSEL : opcode_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: state_d = S_IF;
            S_IF:   state_d = S_ID;
            S_ID:   state_d = S_EX;
            S_EX: begin
                if (!dec_legal) begin
`ifdef CU_ILLEGAL_TRAP_EN
                    state_d = S_HALT;
`else
                    state_d = S_IF;
`endif
                end else if (dec_is_mem) begin
                    state_d = S_MEM;
                end else if (dec_has_wb) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_IF;
                end
            end
            S_MEM:  state_d = dec_is_store ? S_IF : S_WB;
            S_WB:   state_d = S_IF;
`ifdef CU_ILLEGAL_TRAP_EN
            S_HALT: state_d = S_HALT;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        PC_en   = (state_q == S_IF);
        ID_en   = (state_q == S_ID);
        EX_en   = (state_q == S_EX);
        MEM_en  = (state_q == S_MEM);
        WB_en   = (state_q == S_WB);
        Jump_en = dec_jump;
        imm_en  = dec_imm;
        EXPC_en = dec_expc;
        L_or_S  = dec_l_or_s;
        WB_Ctrl = dec_wb_ctrl;
`ifdef CU_ILLEGAL_TRAP_EN
        illegal = 1'b0;
        if (state_q == S_HALT) begin
            illegal = 1'b1;
            Jump_en = 1'b0;
            imm_en  = 1'b0;
            EXPC_en = 1'b0;
            L_or_S  = 1'b0;
            WB_Ctrl = WB_ALU;
        end
`endif
    end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - scoreboard bench for control_unit; build with CU_ILLEGAL_TRAP_EN to cover the trap
module tb_control_unit;

    logic       clk;
    logic       rst;
    logic [6:0] ALUSEL;
    logic       PC_en, ID_en, EX_en, MEM_en, WB_en;
    logic       Jump_en, imm_en, EXPC_en, L_or_S;
    logic [1:0] WB_Ctrl;
    logic       illegal_w;

    control_unit dut (
        .clk     (clk),
        .rst     (rst),
        .ALUSEL  (ALUSEL),
        .PC_en   (PC_en),
        .ID_en   (ID_en),
        .EX_en   (EX_en),
        .MEM_en  (MEM_en),
        .WB_en   (WB_en),
        .Jump_en (Jump_en),
        .imm_en  (imm_en),
        .EXPC_en (EXPC_en),
        .L_or_S  (L_or_S),
        .WB_Ctrl (WB_Ctrl)
`ifdef CU_ILLEGAL_TRAP_EN
        ,
        .illegal (illegal_w)
`endif
    );

`ifndef CU_ILLEGAL_TRAP_EN
    assign illegal_w = 1'b0;
`endif

    initial clk = 1'b1;
    always #5 clk = ~clk;

    // {illegal, PC, ID, EX, MEM, WB, Jump, imm, EXPC, L_or_S, WB_Ctrl[1:0]}
    logic [11:0] act;
    assign act = {illegal_w, PC_en, ID_en, EX_en, MEM_en, WB_en,
                  Jump_en, imm_en, EXPC_en, L_or_S, WB_Ctrl};

    localparam logic [4:0] ST_NONE = 5'b00000;
    localparam logic [4:0] ST_IF   = 5'b10000;
    localparam logic [4:0] ST_ID   = 5'b01000;
    localparam logic [4:0] ST_EX   = 5'b00100;
    localparam logic [4:0] ST_MEM  = 5'b00010;
    localparam logic [4:0] ST_WB   = 5'b00001;

    typedef struct {
        logic [11:0] v;
        logic        is_id;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    int          tests_run = 0;
    int          fails = 0;
    logic [5:0]  prev_dec;

    // {Jump, imm, EXPC, L_or_S, WB_Ctrl}
    function automatic logic [5:0] exp_dec(input logic [6:0] op);
        case (op)
            7'b0000011: return 6'b0100_01;
            7'b0100011: return 6'b0101_00;
            7'b0110011: return 6'b0000_00;
            7'b0010011: return 6'b0100_00;
            7'b0110111: return 6'b0100_11;
            7'b0010111: return 6'b0110_00;
            7'b1101111: return 6'b1110_10;
            7'b1100111: return 6'b1100_10;
            7'b1100011: return 6'b1010_00;
            default:    return 6'b0000_00;
        endcase
    endfunction

    function automatic bit op_legal(input logic [6:0] op);
        case (op)
            7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b0110111,
            7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic exp_t mk(input logic ill, input logic [4:0] st, input logic [5:0] d,
                                input string name, input string stage);
        exp_t e;
        e.v     = {ill, st, d};
        e.is_id = (st == ST_ID);
        e.tag   = $sformatf("%s:%s", name, stage);
        return e;
    endfunction

    // Enters and leaves at a negedge with the DUT in IF; stop_after>0 aborts mid-instruction.
    task automatic run_instr(input logic [6:0] op, input string name, input int stop_after);
        logic [5:0] d;
        exp_t       e;
        int         n;
        bit         trapped;
        d       = exp_dec(op);
        trapped = 1'b0;
        sb.push_back(mk(1'b0, ST_IF, prev_dec, name, "IF"));
        sb.push_back(mk(1'b0, ST_ID, prev_dec, name, "ID"));
        sb.push_back(mk(1'b0, ST_EX, d, name, "EX"));
        if (op == 7'b0000011) begin
            sb.push_back(mk(1'b0, ST_MEM, d, name, "MEM"));
            sb.push_back(mk(1'b0, ST_WB, d, name, "WB"));
        end else if (op == 7'b0100011) begin
            sb.push_back(mk(1'b0, ST_MEM, d, name, "MEM"));
        end else if (op_legal(op) && op != 7'b1100011) begin
            sb.push_back(mk(1'b0, ST_WB, d, name, "WB"));
        end
`ifdef CU_ILLEGAL_TRAP_EN
        if (!op_legal(op)) begin
            trapped = 1'b1;
            for (int k = 0; k < 3; k++)
                sb.push_back(mk(1'b1, ST_NONE, 6'b0, name, "HALT"));
        end
`endif
        n = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            tests_run++;
            if (act !== e.v) begin
                fails++;
                $display("FAIL %s actual=%b required=%b", e.tag, act, e.v);
            end
            n++;
            if (stop_after > 0 && n == stop_after) begin
                sb.delete();
                break;
            end
            ALUSEL = e.is_id ? op : 7'($urandom);
            @(negedge clk);
        end
        if (stop_after == 0) begin
            prev_dec = d;
            if (trapped) begin
                rst = 1'b0;
                @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                prev_dec = 6'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst    = 1'b0;
        ALUSEL = 7'b0000000;
        prev_dec = 6'b0;
        #2;
        tests_run++;
        if (act !== 12'b0) begin
            fails++;
            $display("FAIL reset_hold actual=%b required=%b", act, 12'b0);
        end
        ALUSEL = 7'b1101111;
        #2;
        tests_run++;
        if (act !== 12'b0) begin
            fails++;
            $display("FAIL reset_hold_alusel actual=%b required=%b", act, 12'b0);
        end
        #1 rst = 1'b1;
        #1;
        tests_run++;
        if (act !== 12'b0) begin
            fails++;
            $display("FAIL reset_idle actual=%b required=%b", act, 12'b0);
        end
        @(negedge clk);
        run_instr(7'b0110011, "reset_first_op", 0);
    endtask

    task automatic test_illegal();
        run_instr(7'b0000101, "illegal_a", 0);
        run_instr(7'b0100101, "illegal_b", 0);
    endtask

    task automatic test_load();
        run_instr(7'b0000011, "load", 0);
    endtask

    task automatic test_store();
        run_instr(7'b0100011, "store", 0);
    endtask

    task automatic test_jump();
        run_instr(7'b1101111, "jal", 0);
        run_instr(7'b1100011, "branch", 0);
        run_instr(7'b0110111, "lui", 0);
    endtask

    task automatic test_back_to_back();
        logic [6:0] ops [9];
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b0110111,
                7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011};
        for (int i = 0; i < 24; i++)
            run_instr(ops[$urandom_range(0, 8)], $sformatf("b2b%0d", i), 0);
    endtask

    task automatic test_reset_mid_ex();
        run_instr(7'b1101111, "midex_jal", 3);
        rst = 1'b0;
        #1;
        tests_run++;
        if (act !== 12'b0) begin
            fails++;
            $display("FAIL midex_async actual=%b required=%b", act, 12'b0);
        end
        @(negedge clk);
        tests_run++;
        if (act !== 12'b0) begin
            fails++;
            $display("FAIL midex_hold actual=%b required=%b", act, 12'b0);
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if (act !== 12'b0) begin
            fails++;
            $display("FAIL midex_idle actual=%b required=%b", act, 12'b0);
        end
        @(negedge clk);
        prev_dec = 6'b0;
        run_instr(7'b0110111, "midex_restart_lui", 0);
    endtask

    initial begin
        test_reset();
        test_illegal();
        test_load();
        test_store();
        test_jump();
        test_back_to_back();
        test_reset_mid_ex();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
